edge_detector_mc: RTL and testbench
===================================

Name: edge_detector_mc

Overview:
Multi-channel, parametrised edge detector for asynchronous control inputs such as start, capture and rst_capture strobes.
Each channel has the following pipeline:
- input synchroniser
- programmable glitch/debounce filter
- per-channel edge-mode selection (rise/fall/both/off)
- single-cycle event pulse, sticky flag with clear, and an aggregated interrupt
It sits between pad-level/asynchronous control signals and the capture/timer control logic.

Parameters:
N_CH, 4, number of independent channels (1..32)
SYNC_STAGES, 2, synchroniser flop depth per channel (2..4; other values illegal)
FILT_W, 4, width of filter length input and per-channel filter counter

Ports:
clk_i  in  1  system clock
rst_an_i  in  1  asynchronous active-low reset
sig_i  in  N_CH  raw input signals, asynchronous to clk_i
mode_i  in  2*N_CH  per-channel mode, bits [2k+1:2k]: 00 off, 01 rising, 10 falling, 11 both
filt_len_i  in  FILT_W  stability length, shared by all channels; quasi-static
clr_i  in  N_CH  per-channel sticky/counter clear, level-sensitive, synchronous
level_o  out  N_CH  filtered, synchronised level
pulse_o  out  N_CH  one-cycle registered edge event pulse
sticky_o  out  N_CH  latched event flags
irq_o  out  1  OR of sticky_o
cnt_o  out  8*N_CH  per-channel event counters; tied to 0 without EDGE_CNT_EN

Behaviour:
- Clocking and reset:
  - One clock: clk_i. Reset rst_an_i is asynchronous and active-low.
  - While rst_an_i=0, all flops are cleared: synchroniser, filter counters, level_o, pulse_o, sticky_o, cnt_o. Therefore irq_o=0.
- Synchroniser: SYNC_STAGES flops per channel, reset 0. sync_k is the last stage.
- Filter (per channel, counter fc of FILT_W bits, reset 0):
  - sync_k == level_o: fc <= 0.
  - sync_k != level_o and fc >= filt_len_i: level_o <= sync_k, fc <= 0.
  - Otherwise: fc <= fc+1.
  - Result: a change is accepted only after filt_len_i+1 consecutive differing cycles. With filt_len_i=0 there is no filtering.
  - Latency from a sig_i transition (set up before edge 1) to the level_o change is SYNC_STAGES+filt_len_i+1 rising edges.
  - Shorter excursions are discarded entirely, with no pulse.
- Edge pulse:
  - pulse_o[k] is 1 for exactly one cycle: the first cycle in which level_o[k] shows its new value.
  - It is qualified by mode_i sampled in the cycle the level update is registered:
    - 0->1 qualifies for modes 01 and 11.
    - 1->0 qualifies for modes 10 and 11.
    - Mode 00 never pulses, but level_o still tracks.
- Mode changes take effect on the next cycle and do not disturb the filter state.
- Sticky flag:
  - sticky_o[k] sets on pulse_o[k] and clears on clr_i[k].
  - Simultaneous pulse and clear: sticky stays/becomes 1, so no event is lost.
- irq_o is the combinational OR of the sticky flops.
- filt_len_i changed mid-count: compared against the current fc immediately. No counter reset.
- Reset released while sig_i is high: level_o starts at 0, so a rising edge is reported (if enabled) SYNC_STAGES+filt_len_i+1 cycles after release.
- All channels are fully independent; there are no cross-channel interactions.

Optional Feature:
EDGE_CNT_EN
- Defined:
  - Each channel has an 8-bit event counter at cnt_o[8k+7:8k], reset 0.
  - It increments on each pulse_o[k] and saturates at 255.
  - clr_i[k] clears it to 0. Simultaneous clear and pulse loads 1.
  - The counter is updated in the same cycle as sticky_o.
- Undefined: no counter flops; cnt_o is driven to all zeros.

Test Plan:
1. N_CH=4, SYNC_STAGES=2, filt_len_i=0, mode ch0=01; sig_i[0] 0->1 before edge 1 -> level_o[0]=1, pulse_o[0]=1 for one cycle, sticky_o[0]=1, irq_o=1, all after edge 3; pulse_o[0]=0 after edge 4.
2. filt_len_i=3, ch0 mode 01: 3-cycle high glitch -> no pulse, level_o stays 0. Then a 4-cycle high -> level_o=1 and pulse after edge 6 from transition.
3. Ch1 mode 10, rise then fall -> only the fall produces a pulse. Mode 11 -> both pulse. Mode 00 -> no pulse, level_o[1] still toggles, sticky_o[1]=0.
4. ch2 sticky=1, then clr_i[2]=1 in the same cycle as a new pulse_o[2] -> sticky_o[2]=1 afterwards. Clear alone -> 0 next cycle; irq_o drops once no flag is set.
5. EDGE_CNT_EN defined, ch3 mode 11, 150 full toggles (300 edges) -> cnt_o[31:24]=255. clr_i[3] -> 0. Clear plus pulse in the same cycle -> 1. Macro undefined -> cnt_o=0 throughout.
6. sig_i[0]=1 steady, assert rst_an_i low mid-run -> all outputs 0 asynchronously (before the next clock edge). Release -> rising pulse on ch0 after edge 3 (filt_len_i=0).

Source files
------------

// File: rtl/edge_detector_mc_if.sv
// Bus bundle for edge_detector_mc: raw inputs, per-channel controls and event outputs.
// master = control/capture logic side, slave = detector side.
interface edge_detector_mc_if #(
  parameter int N_CH   = 4,
  parameter int FILT_W = 4
);
  logic [N_CH-1:0]   sig_i;
  logic [2*N_CH-1:0] mode_i;
  logic [FILT_W-1:0] filt_len_i;
  logic [N_CH-1:0]   clr_i;
  logic [N_CH-1:0]   level_o;
  logic [N_CH-1:0]   pulse_o;
  logic [N_CH-1:0]   sticky_o;
  logic              irq_o;
  logic [8*N_CH-1:0] cnt_o;

  modport master (
    output sig_i, mode_i, filt_len_i, clr_i,
    input  level_o, pulse_o, sticky_o, irq_o, cnt_o
  );

  modport slave (
    input  sig_i, mode_i, filt_len_i, clr_i,
    output level_o, pulse_o, sticky_o, irq_o, cnt_o
  );
endinterface

// File: rtl/edge_detector_mc.sv
// Multi-channel synchronised, debounced edge detector with sticky flags and irq.
// Optional 8-bit saturating per-channel event counters under EDGE_CNT_EN.
module edge_detector_mc_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk_i,
  input  logic              rst_an_i,
  input  logic              sig_i,
  input  logic [1:0]        mode_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic              clr_i,
  output logic              level_o,
  output logic              pulse_o,
  output logic              sticky_o,
  output logic [7:0]        cnt_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      fc_q, fc_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   sticky_q, sticky_d;
  logic                   sync_k, ev;

  assign sync_k = sync_q[SYNC_STAGES-1];

  always_comb begin
    fc_d    = fc_q;
    level_d = level_q;
    if (sync_k == level_q) begin
      fc_d = '0;
    end else if (fc_q >= filt_len_i) begin
      level_d = sync_k;
      fc_d    = '0;
    end else begin
      fc_d = fc_q + 1'b1;
    end
    // Event is qualified against the mode seen on the edge that commits the level.
    ev       = (level_d & ~level_q & mode_i[0]) | (~level_d & level_q & mode_i[1]);
    pulse_d  = ev;
    sticky_d = ev | (sticky_q & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      sync_q   <= '0;
      fc_q     <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_i};
      fc_q     <= fc_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef EDGE_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = {7'd0, ev};
    else if (ev && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`else
  assign cnt_o = '0;
`endif

  assign level_o  = level_q;
  assign pulse_o  = pulse_q;
  assign sticky_o = sticky_q;
endmodule

module edge_detector_mc #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input logic               clk_i,
  input logic               rst_an_i,
  edge_detector_mc_if.slave bus
);
  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("edge_detector_mc: SYNC_STAGES must be 2..4");
    end
  endgenerate

  logic [N_CH-1:0]   level_w, pulse_w, sticky_w;
  logic [8*N_CH-1:0] cnt_w;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    edge_detector_mc_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_W     (FILT_W)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_an_i  (rst_an_i),
      .sig_i     (bus.sig_i[k]),
      .mode_i    (bus.mode_i[2*k +: 2]),
      .filt_len_i(bus.filt_len_i),
      .clr_i     (bus.clr_i[k]),
      .level_o   (level_w[k]),
      .pulse_o   (pulse_w[k]),
      .sticky_o  (sticky_w[k]),
      .cnt_o     (cnt_w[8*k +: 8])
    );
  end

  assign bus.level_o  = level_w;
  assign bus.pulse_o  = pulse_w;
  assign bus.sticky_o = sticky_w;
  assign bus.irq_o    = |sticky_w;
  assign bus.cnt_o    = cnt_w;
endmodule

// File: tb/tb_edge_detector_mc.sv
// Directed bench for edge_detector_mc; expected pulses go into a scoreboard queue
// and a negedge monitor pops one entry per observed pulse bit.
module tb_edge_detector_mc;
  localparam int N_CH = 4, SYNC = 2, FW = 4;
`ifdef EDGE_CNT_EN
  localparam logic [7:0] CNT_FULL = 8'd255, CNT_ONE = 8'd1;
`else
  localparam logic [7:0] CNT_FULL = 8'd0,   CNT_ONE = 8'd0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  edge_detector_mc_if #(.N_CH(N_CH), .FILT_W(FW)) bus();
  edge_detector_mc #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_W(FW)) dut (
    .clk_i   (clk),
    .rst_an_i(rst_n),
    .bus     (bus)
  );

  typedef struct { int cyc; int ch; } ev_t;
  ev_t exp_q[$];
  int cyc = 0, errors = 0, checks = 0;
  int c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int t, input int ch);
    ev_t e;
    e.cyc = t; e.ch = ch;
    exp_q.push_back(e);
  endtask

  task automatic set_mode(input int k, input logic [1:0] m);
    bus.mode_i[2*k +: 2] = m;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        if (bus.pulse_o[k]) begin : mon
          ev_t e;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected: got pulse ch%0d at cyc %0d, expected none", k, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.ch != k) begin
              errors++;
              $display("FAIL pulse_match: got ch%0d cyc %0d expected ch%0d cyc %0d", k, cyc, e.ch, e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    bus.sig_i = '0; bus.mode_i = '0; bus.filt_len_i = '0; bus.clr_i = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_level",  32'(bus.level_o),  0);
    check("rst_pulse",  32'(bus.pulse_o),  0);
    check("rst_sticky", 32'(bus.sticky_o), 0);
    check("rst_irq",    32'(bus.irq_o),    0);
    check("rst_cnt",    bus.cnt_o,         0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic rising edge, no filtering
    set_mode(0, 2'b01);
    c = cyc; bus.sig_i[0] = 1'b1; push(c+3, 0);
    wait_to(c+2); check("t1_level_early", 32'(bus.level_o[0]), 0);
    wait_to(c+3);
    check("t1_level",  32'(bus.level_o[0]),  1);
    check("t1_sticky", 32'(bus.sticky_o[0]), 1);
    check("t1_irq",    32'(bus.irq_o),       1);

    // Falling edge not enabled, then debounce with filt_len=3
    c = cyc; bus.sig_i[0] = 1'b0;
    wait_to(c+4);
    check("t2_fall_level",  32'(bus.level_o[0]),  0);
    check("t2_fall_sticky", 32'(bus.sticky_o[0]), 1);
    bus.clr_i[0] = 1'b1; tick(); bus.clr_i = '0;
    check("t2_clr_sticky", 32'(bus.sticky_o[0]), 0);
    check("t2_clr_irq",    32'(bus.irq_o),       0);
    bus.filt_len_i = 4'd3;
    c = cyc; bus.sig_i[0] = 1'b1; tick(); tick(); tick(); bus.sig_i[0] = 1'b0;
    wait_to(c+10);
    check("t2_glitch_level",  32'(bus.level_o[0]),  0);
    check("t2_glitch_sticky", 32'(bus.sticky_o[0]), 0);
    c = cyc; bus.sig_i[0] = 1'b1; push(c+6, 0);
    wait_to(c+5); check("t2_filt_early", 32'(bus.level_o[0]), 0);
    wait_to(c+6); check("t2_filt_level", 32'(bus.level_o[0]), 1);
    bus.sig_i[0] = 1'b0; bus.filt_len_i = '0;
    c = cyc; wait_to(c+5);
    check("t2_back_low", 32'(bus.level_o[0]), 0);

    // Ch1 mode sweep: fall only, both, off
    set_mode(1, 2'b10);
    c = cyc; bus.sig_i[1] = 1'b1; wait_to(c+4);
    check("t3_rise_level",  32'(bus.level_o[1]),  1);
    check("t3_rise_sticky", 32'(bus.sticky_o[1]), 0);
    c = cyc; bus.sig_i[1] = 1'b0; push(c+3, 1); wait_to(c+4);
    check("t3_fall_level",  32'(bus.level_o[1]),  0);
    check("t3_fall_sticky", 32'(bus.sticky_o[1]), 1);
    set_mode(1, 2'b11);
    c = cyc; bus.sig_i[1] = 1'b1; push(c+3, 1); wait_to(c+4);
    c = cyc; bus.sig_i[1] = 1'b0; push(c+3, 1); wait_to(c+4);
    bus.clr_i[1] = 1'b1; tick(); bus.clr_i = '0;
    set_mode(1, 2'b00);
    c = cyc; bus.sig_i[1] = 1'b1; wait_to(c+4);
    check("t3_off_level_hi", 32'(bus.level_o[1]), 1);
    c = cyc; bus.sig_i[1] = 1'b0; wait_to(c+4);
    check("t3_off_level_lo", 32'(bus.level_o[1]),  0);
    check("t3_off_sticky",   32'(bus.sticky_o[1]), 0);

    // Sticky clear vs. simultaneous pulse on ch2
    bus.clr_i = '1; tick(); bus.clr_i = '0;
    check("t4_irq_clear", 32'(bus.irq_o), 0);
    set_mode(2, 2'b01);
    c = cyc; bus.sig_i[2] = 1'b1; push(c+3, 2); wait_to(c+3);
    check("t4_sticky_set", 32'(bus.sticky_o[2]), 1);
    check("t4_irq_set",    32'(bus.irq_o),       1);
    c = cyc; bus.sig_i[2] = 1'b0; wait_to(c+4);
    c = cyc; bus.sig_i[2] = 1'b1; push(c+3, 2);
    wait_to(c+2); bus.clr_i[2] = 1'b1; tick(); bus.clr_i = '0;
    check("t4_clr_and_pulse", 32'(bus.sticky_o[2]), 1);
    bus.clr_i[2] = 1'b1; tick(); bus.clr_i = '0;
    check("t4_clr_alone", 32'(bus.sticky_o[2]), 0);
    check("t4_irq_drop",  32'(bus.irq_o),       0);

    // Counter saturation on ch3 (zero when the counter feature is absent)
    set_mode(3, 2'b11);
    for (int i = 0; i < 300; i++) begin
      c = cyc; bus.sig_i[3] = ~bus.sig_i[3]; push(c+3, 3);
      tick(); tick();
    end
    tick(); tick(); tick(); tick();
    check("t5_cnt_sat",    bus.cnt_o, {CNT_FULL, 24'h0});
    check("t5_sticky3",    32'(bus.sticky_o[3]), 1);
    bus.clr_i[3] = 1'b1; tick(); bus.clr_i = '0;
    check("t5_cnt_clr",    bus.cnt_o, 0);
    check("t5_sticky_clr", 32'(bus.sticky_o[3]), 0);
    c = cyc; bus.sig_i[3] = ~bus.sig_i[3]; push(c+3, 3);
    wait_to(c+2); bus.clr_i[3] = 1'b1; tick(); bus.clr_i = '0;
    check("t5_cnt_clr_pulse", bus.cnt_o, {CNT_ONE, 24'h0});
    check("t5_sticky_both",   32'(bus.sticky_o[3]), 1);

    // Asynchronous reset with ch0 held high, then rising report after release
    set_mode(1, 2'b00); set_mode(2, 2'b00); set_mode(3, 2'b00);
    c = cyc; bus.sig_i[0] = 1'b1; push(c+3, 0); wait_to(c+6);
    check("t6_pre_level", 32'(bus.level_o[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_level",  32'(bus.level_o),  0);
    check("t6_async_sticky", 32'(bus.sticky_o), 0);
    check("t6_async_irq",    32'(bus.irq_o),    0);
    check("t6_async_cnt",    bus.cnt_o,         0);
    tick(); tick();
    rst_n = 1'b1;
    c = cyc; push(c+3, 0);
    wait_to(c+2); check("t6_rel_early", 32'(bus.level_o[0]), 0);
    wait_to(c+3);
    check("t6_rel_level",  32'(bus.level_o[0]),  1);
    check("t6_rel_sticky", 32'(bus.sticky_o[0]), 1);
    tick(); tick(); tick(); tick();
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
